// File: rtl/rd_stream_fetch.sv
// rd_stream_fetch: streaming cache-line prefetcher with an in-order reorder buffer.
// On a start pulse it reads num_clines consecutive lines beginning at base_addr,
// tags each read with its reorder slot, accepts responses in any order and hands
// the lines to the consumer strictly in address order.
//
// Build option: define RD_STREAM_FETCH_ERRCHK_EN to track a pending bit per slot.
// With it, responses that carry a stale or out-of-range tag are dropped and they
// raise the sticky err flag. Without it, err is tied low and every response that
// arrives outside IDLE is written.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle job start, sampled only in IDLE
//   base_addr           first line address of the job
//   num_clines          number of lines in the job (0 completes immediately)
//   rd_req_addr/mdata   registered read request address and slot tag
//   rd_req_en           registered read request strobe
//   rd_req_almostfull   request channel backpressure
//   rd_rsp_valid/mdata/data  read response strobe, tag and line
//   out_valid/data/last in-order line to the consumer, last marks the final line
//   out_ready           consumer accepts the current line
//   busy                job in FETCH or DRAIN
//   done                one-cycle completion pulse
//   err                 sticky tag-error flag
module rd_stream_fetch #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_LMT-1:0]    base_addr,
    input  logic [31:0]            num_clines,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    output logic                   out_valid,
    output logic [CACHE_WIDTH-1:0] out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [ADDR_LMT-1:0]      r_base;
    logic [31:0]              r_num;
    logic [31:0]              r_issued;
    logic [31:0]              r_delivered;
    logic [IDXW-1:0]          r_head;
    logic [DEPTH-1:0]         r_filled;
    logic [CACHE_WIDTH-1:0]   r_mem [DEPTH];

    logic                     r_req_en;
    logic [ADDR_LMT-1:0]      r_req_addr;
    logic [MDATA-1:0]         r_req_mdata;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [CACHE_WIDTH-1:0]   r_out_data;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_start_job;
    logic                     w_issue;
    logic                     w_pop;
    logic                     w_rsp_live;
    logic                     w_fill;
    logic [IDXW-1:0]          w_fill_idx;
    logic [IDXW-1:0]          w_issue_idx;
    logic [IDXW-1:0]          w_head_nxt;
    logic [DEPTH-1:0]         w_filled_nxt;
    logic [31:0]              w_inflight;
    logic [31:0]              w_delivered_nxt;
    logic                     w_out_valid_nxt;
    logic                     w_out_last_nxt;
    logic [CACHE_WIDTH-1:0]   w_out_data_nxt;

    assign w_inflight  = r_issued - r_delivered;
    assign w_issue_idx = r_issued[IDXW-1:0];
    assign w_fill_idx  = rd_rsp_mdata[IDXW-1:0];
    assign w_rsp_live  = rd_rsp_valid && (r_state != S_IDLE);
    assign w_pop       = r_out_valid && out_ready;

    // Next-state and issue decision; inflight counts requested-but-not-popped
    // lines from registered counters, so a slot freed by a pop is reusable next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start_job = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_job = 1'b1;
                    w_state_nxt = (num_clines == 32'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_issued == r_num) begin
                    w_state_nxt = S_DRAIN;
                end else if (!rd_req_almostfull && (w_inflight < 32'(DEPTH))) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_delivered == r_num) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef RD_STREAM_FETCH_ERRCHK_EN
    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;
    logic             r_err;
    logic             w_rsp_bad;

    // A response is only trusted if its slot has a request in flight and the tag
    // carries nothing above the slot index.
    assign w_rsp_bad = w_rsp_live &&
                       (!r_pending[w_fill_idx] || ((rd_rsp_mdata >> IDXW) != '0));
    assign w_fill    = w_rsp_live && !w_rsp_bad;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_start_job) begin
            w_pending_nxt = '0;
        end
        if (w_fill) begin
            w_pending_nxt[w_fill_idx] = 1'b0;
        end
        if (w_issue) begin
            w_pending_nxt[w_issue_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_mdata;

    assign w_fill         = w_rsp_live;
    assign w_unused_mdata = ^(rd_rsp_mdata >> IDXW);
    assign err            = 1'b0;
`endif

    // Reorder-buffer bookkeeping; pop clears the head slot before a fill of another slot lands.
    always_comb begin
        w_filled_nxt = r_filled;
        if (w_start_job) begin
            w_filled_nxt = '0;
        end
        if (w_pop) begin
            w_filled_nxt[r_head] = 1'b0;
        end
        if (w_fill) begin
            w_filled_nxt[w_fill_idx] = 1'b1;
        end
    end

    assign w_head_nxt      = w_start_job ? '0 : (r_head + IDXW'(w_pop));
    assign w_delivered_nxt = w_start_job ? 32'd0 : (r_delivered + 32'(w_pop));
    assign w_out_valid_nxt = w_filled_nxt[w_head_nxt];
    assign w_out_last_nxt  = w_out_valid_nxt && (w_delivered_nxt == (r_num - 32'd1));
    // Bypass so a line written into the new head slot is presented on the next cycle.
    assign w_out_data_nxt  = (w_fill && (w_fill_idx == w_head_nxt)) ? rd_rsp_data
                                                                    : r_mem[w_head_nxt];

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_mem[w_fill_idx] <= rd_rsp_data;
        end
    end

    // Job registers, request port and consumer port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_head      <= '0;
            r_filled    <= '0;
            r_req_en    <= 1'b0;
            r_req_addr  <= '0;
            r_req_mdata <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start_job) begin
                r_base <= base_addr;
                r_num  <= num_clines;
            end
            r_issued    <= w_start_job ? 32'd0 : (r_issued + 32'(w_issue));
            r_delivered <= w_delivered_nxt;
            r_head      <= w_head_nxt;
            r_filled    <= w_filled_nxt;
            r_req_en    <= w_issue;
            if (w_issue) begin
                r_req_addr  <= r_base + ADDR_LMT'(r_issued);
                r_req_mdata <= MDATA'(w_issue_idx);
            end
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_data  <= w_out_data_nxt;
            r_busy      <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign rd_req_en    = r_req_en;
    assign rd_req_addr  = r_req_addr;
    assign rd_req_mdata = r_req_mdata;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign out_data     = r_out_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_rd_stream_fetch.sv
// Directed bench for rd_stream_fetch: in-order and reordered jobs, buffer-full
// stall, request backpressure, address wrap, empty job, mid-job reset, and the
// tag-error path when built with RD_STREAM_FETCH_ERRCHK_EN.
module tb_rd_stream_fetch;

    localparam int unsigned AW = 20;
    localparam int unsigned MW = 14;
    localparam int unsigned CW = 512;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [31:0]   num_clines;
    logic [AW-1:0] rd_req_addr;
    logic [MW-1:0] rd_req_mdata;
    logic          rd_req_en;
    logic          rd_req_almostfull;
    logic          rd_rsp_valid;
    logic [MW-1:0] rd_rsp_mdata;
    logic [CW-1:0] rd_rsp_data;
    logic          out_valid;
    logic [CW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    rd_stream_fetch #(
        .ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .DEPTH(DP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_clines(num_clines), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
        .rd_req_en(rd_req_en), .rd_req_almostfull(rd_req_almostfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [AW-1:0] req_addr [256];
    logic [MW-1:0] req_tag  [256];
    logic [CW-1:0] pop_data [256];
    logic          pop_last [256];
    int            pop_cyc  [256];
    int            done_cyc [64];
    int            req_n  = 0;
    int            pop_n  = 0;
    int            done_n = 0;
    int            cyc    = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rd_req_en && req_n < 256) begin
            req_addr[req_n] <= rd_req_addr;
            req_tag[req_n]  <= rd_req_mdata;
            req_n           <= req_n + 1;
        end
        if (out_valid && out_ready && pop_n < 256) begin
            pop_data[pop_n] <= out_data;
            pop_last[pop_n] <= out_last;
            pop_cyc[pop_n]  <= cyc;
            pop_n           <= pop_n + 1;
        end
        if (done && done_n < 64) begin
            done_cyc[done_n] <= cyc;
            done_n           <= done_n + 1;
        end
    end

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int            rsp_i = 0;
    int            req0, pop0, done0, snap;
    logic [AW-1:0] job_base;
    int            job_num;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input logic [AW-1:0] a);
        return {16{a, 12'hDA7}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle; optionally answers the oldest unanswered request.
    task automatic step(input bit respond);
        if (respond && rsp_i < req_n) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_mdata = req_tag[rsp_i];
            rd_rsp_data  = mk(req_addr[rsp_i]);
            rsp_i++;
        end
        tick();
        rd_rsp_valid = 1'b0;
    endtask

    task automatic resp_one(input int k);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = req_tag[k];
        rd_rsp_data  = mk(req_addr[k]);
        tick();
        rd_rsp_valid = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input int n);
        job_base   = b;
        job_num    = n;
        req0       = req_n;
        pop0       = pop_n;
        done0      = done_n;
        rsp_i      = req_n;
        base_addr  = b;
        num_clines = 32'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while ((req_n - req0) < n && k < budget) begin
            step(1'b0);
            k++;
        end
        chk({tag, "_reqs_seen"}, 64'(req_n - req0), 64'(n));
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int k = 0;
        while (done_n == done0 && k < budget) begin
            step(1'b1);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_n != done0), 64'd1);
        repeat (3) step(1'b0);
    endtask

    // Compares the whole job against the address-ordered model.
    task automatic check_job(input string tag, input logic exp_err);
        logic [AW-1:0] ea;
        int            d;
        chk({tag, "_req_count"}, 64'(req_n - req0), 64'(job_num));
        chk({tag, "_pop_count"}, 64'(pop_n - pop0), 64'(job_num));
        chk({tag, "_done_pulses"}, 64'(done_n - done0), 64'd1);
        for (int i = 0; i < job_num; i++) begin
            ea = job_base + AW'(i);
            chk($sformatf("%s_addr%0d", tag, i), 64'(req_addr[req0 + i]), 64'(ea));
            chk($sformatf("%s_tag%0d", tag, i), 64'(req_tag[req0 + i]), 64'(i % DP));
            chk_line($sformatf("%s_data%0d", tag, i), pop_data[pop0 + i], mk(ea));
            chk($sformatf("%s_last%0d", tag, i), 64'(pop_last[pop0 + i]), 64'(i == job_num - 1));
        end
        d = done_cyc[done0] - pop_cyc[pop0 + job_num - 1];
        chk({tag, "_done_after_pop"}, 64'(d >= 1 && d <= 2), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        base_addr         = '0;
        num_clines        = '0;
        rd_req_almostfull = 1'b0;
        rd_rsp_valid      = 1'b0;
        rd_rsp_mdata      = '0;
        rd_rsp_data       = '0;
        out_ready         = 1'b0;
        repeat (3) tick();
        chk("rst_req_en", 64'(rd_req_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        tick();

        // In-order job from 0x100.
        out_ready = 1'b1;
        start_job(20'h00100, 4);
        chk("t1_busy", 64'(busy), 64'd1);
        run_to_done("t1", 100);
        check_job("t1", 1'b0);

        // Responses returned as tags 3,1,0,2.
        start_job(20'h00200, 4);
        wait_reqs("t2", 4, 30);
        resp_one(req0 + 3);
        resp_one(req0 + 1);
        repeat (2) step(1'b0);
        chk("t2_hold_for_line0", 64'(pop_n - pop0), 64'd0);
        resp_one(req0 + 0);
        resp_one(req0 + 2);
        rsp_i = req_n;
        run_to_done("t2", 50);
        check_job("t2", 1'b0);

        // Consumer stalled: issue stops once all buffer slots are taken.
        out_ready = 1'b0;
        start_job(20'h00300, 20);
        repeat (30) step(1'b1);
        chk("t3_stall_reqs", 64'(req_n - req0), 64'd8);
        chk("t3_stall_req_en", 64'(rd_req_en), 64'd0);
        chk("t3_stall_valid", 64'(out_valid), 64'd1);
        chk_line("t3_stall_data", out_data, mk(20'h00300));
        out_ready = 1'b1;
        run_to_done("t3", 400);
        check_job("t3", 1'b0);

        // Backpressure window of 10 cycles mid-job.
        start_job(20'h00400, 12);
        repeat (3) step(1'b1);
        rd_req_almostfull = 1'b1;
        step(1'b1);
        snap = req_n;
        repeat (9) step(1'b1);
        chk("t4_af_window", 64'(req_n), 64'(snap));
        rd_req_almostfull = 1'b0;
        run_to_done("t4", 200);
        check_job("t4", 1'b0);

        // Address wrap at the top of the line-address space.
        start_job(20'hFFFFE, 4);
        run_to_done("t5", 100);
        check_job("t5", 1'b0);
        chk("t5_wrap_addr2", 64'(req_addr[req0 + 2]), 64'h0);

        // Empty job: done on the next cycle, no requests.
        start_job(20'h00700, 0);
        chk("t6_done_now", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        tick();
        chk("t6_done_drop", 64'(done), 64'd0);
        repeat (3) step(1'b0);
        chk("t6_no_reqs", 64'(req_n - req0), 64'd0);
        chk("t6_one_done", 64'(done_n - done0), 64'd1);

        // Reset after 2 of 4 responses; late responses must be ignored.
        out_ready = 1'b0;
        start_job(20'h00500, 4);
        wait_reqs("t7", 4, 30);
        resp_one(req0 + 0);
        resp_one(req0 + 1);
        step(1'b0);
        chk("t7_pre_valid", 64'(out_valid), 64'd1);
        chk("t7_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", 64'(out_valid), 64'd0);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_req_en", 64'(rd_req_en), 64'd0);
        chk("t7_rst_last", 64'(out_last), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        resp_one(req0 + 2);
        resp_one(req0 + 3);
        resp_one(req0 + 0);
        repeat (3) step(1'b0);
        chk("t7_late_valid", 64'(out_valid), 64'd0);
        chk("t7_late_busy", 64'(busy), 64'd0);
        chk("t7_late_err", 64'(err), 64'd0);

        // Clean job after the reset.
        out_ready = 1'b1;
        start_job(20'h00540, 4);
        run_to_done("t8", 100);
        check_job("t8", 1'b0);

`ifdef RD_STREAM_FETCH_ERRCHK_EN
        // Tag 5 is not pending: dropped and err latches until reset.
        out_ready = 1'b0;
        start_job(20'h00600, 2);
        wait_reqs("t9", 2, 30);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = 14'd5;
        rd_rsp_data  = mk(20'h0BAD0);
        tick();
        rd_rsp_valid = 1'b0;
        step(1'b0);
        chk("t9_err_set", 64'(err), 64'd1);
        chk("t9_no_valid", 64'(out_valid), 64'd0);
        resp_one(req0 + 0);
        resp_one(req0 + 1);
        rsp_i     = req_n;
        out_ready = 1'b1;
        run_to_done("t9", 50);
        check_job("t9", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t9_err_cleared", 64'(err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
